traffic_phase_scheduler: RTL and testbench
==========================================

Name: traffic_phase_scheduler

Overview:
Demand-actuated phase scheduler for the four-way intersection (N, E, S, W).
- Latches vehicle-sensor requests per approach and grants green round-robin, one approach at a time.
- Enforces min/max green, yellow and all-red clearance timing from an internal one-second prescaler.
- Drives the same 2-bit light codes as the fixed-cycle controller (red=00, yellow=01, green=10) and replaces it where sensors are fitted.

Parameters:
TICK_DIV, 50000000, clk cycles per timing tick (1 s at 50 MHz); override small for simulation
STARTUP_T, 3, ticks of all-yellow after reset
GREEN_MIN, 5, minimum green ticks before yielding
GREEN_MAX, 15, maximum green ticks while another approach is pending
YELLOW_T, 2, yellow ticks
ALLRED_T, 1, all-red clearance ticks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  4  sensor requests, bit0=N bit1=E bit2=S bit3=W, level
north  out  2  north light code
east  out  2  east light code
south  out  2  south light code
west  out  2  west light code
grant  out  4  one-hot approach currently green/yellow, 0 otherwise
phase  out  3  state code: 0 STARTUP, 1 ALLRED, 2 GREEN, 3 YELLOW
pending  out  4  latched request vector

Behaviour:
- Interface: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk. All outputs are registered.
- Reset values:
  - state STARTUP; all four lights 01; grant 0; phase 0; pending 0.
  - last-served pointer = 3 (W), so N is served first.
  - prescaler 0; elapsed 0.
- Tick generation: prescaler counts 0..TICK_DIV-1; tick asserts on the cycle count==TICK_DIV-1.
  - Prescaler and elapsed clear on every state change, so a state of duration D lasts exactly D*TICK_DIV cycles.
  - elapsed is 8-bit and saturates at 255.
- Pending latch:
  - pending[j] sets on any cycle with req[j]=1, unless the state is GREEN(j).
  - pending[j] clears on the cycle GREEN(j) is entered.
  - Set and clear in the same cycle: clear wins.
- STARTUP: all lights yellow. After STARTUP_T ticks -> ALLRED.
- ALLRED: all lights red, grant 0.
  - Once elapsed>=ALLRED_T and pending!=0: select the first set bit searching from (last+1) mod 4 upward with wrap, set last to it, go to GREEN(sel).
  - If pending==0: remain in ALLRED. elapsed saturates, and a request arriving later grants on the following cycle.
- GREEN(i): light i=10, others 00, grant=1<<i. Transition to YELLOW(i) when others=|(pending & ~(1<<i)) and either:
  - elapsed>=GREEN_MIN and req[i]=0 (gap-out), or
  - elapsed>=GREEN_MAX (max-out).
  - With others=0 the block rests in green indefinitely.
- YELLOW(i): light i=01, others 00, grant=1<<i. After YELLOW_T ticks -> ALLRED.
- Exactly one approach is non-red in GREEN/YELLOW. A green-to-green change always passes through YELLOW then ALLRED.
- Reset asserted mid-phase: next edge forces STARTUP values regardless of state. Pending requests are discarded.
- Unused state encodings: lights all red, next state ALLRED.

Optional Feature:
TRAFFIC_EMERG_PREEMPT_EN.
- Defined: adds ports emerg_req (in, 1) and emerg_dir (in, 2).
  - While emerg_req=1 in GREEN(i) with i!=emerg_dir: go to YELLOW(i) immediately, ignoring GREEN_MIN.
  - At ALLRED expiry, grant emerg_dir directly, ignoring round-robin, and set last=emerg_dir.
  - In GREEN(emerg_dir): hold green while emerg_req=1, ignoring GREEN_MAX.
  - STARTUP is never shortened.
- Undefined: ports absent; behaviour exactly as above.

Test Plan:
TICK_DIV=4 with defaults; reset 2 cycles, no req -> all 01 for 12 cycles, then all 00, phase=1, stays idle.
req=0001 pulse 1 cycle while idle after clearance -> next cycle north=10, grant=0001, pending=0; rests green.
req=1111 held from idle -> greens in order N,E,S,W,N. Each green is 60 cycles (GREEN_MAX) because own req stays high, followed by 8 cycles yellow and 4 cycles all-red.
In GREEN(N) with req=0011 then N released at tick 2 -> yellow starts exactly at elapsed=5 (gap-out at GREEN_MIN), next green is E.
reset asserted during YELLOW(S) -> next edge all lights 01, grant 0, pending 0; after 12 cycles N served first on request.
With TRAFFIC_EMERG_PREEMPT_EN, emerg_req=1, emerg_dir=2 at GREEN(N) elapsed=1 -> N yellow next cycle, then all-red, then south=10, held until emerg_req drops.

Source files
------------

// File: rtl/traffic_phase_scheduler_if.sv
// Signal bundle between the intersection sensors/lights and traffic_phase_scheduler.
// Emergency pre-emption signals exist only when TRAFFIC_EMERG_PREEMPT_EN is defined.
interface traffic_phase_scheduler_if;
    logic [3:0] req;
    logic [1:0] north;
    logic [1:0] east;
    logic [1:0] south;
    logic [1:0] west;
    logic [3:0] grant;
    logic [2:0] phase;
    logic [3:0] pending;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
    logic       emerg_req;
    logic [1:0] emerg_dir;
`endif

    modport master (
        output req,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        output emerg_req,
        output emerg_dir,
`endif
        input  north,
        input  east,
        input  south,
        input  west,
        input  grant,
        input  phase,
        input  pending
    );

    modport slave (
        input  req,
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        input  emerg_req,
        input  emerg_dir,
`endif
        output north,
        output east,
        output south,
        output west,
        output grant,
        output phase,
        output pending
    );
endinterface

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated round-robin phase scheduler for a four-way intersection.
// Optional emergency pre-emption is enabled with `define TRAFFIC_EMERG_PREEMPT_EN.
module traffic_phase_scheduler #(
    parameter int TICK_DIV  = 50000000,
    parameter int STARTUP_T = 3,
    parameter int GREEN_MIN = 5,
    parameter int GREEN_MAX = 15,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input logic                      clk,
    input logic                      reset,
    traffic_phase_scheduler_if.slave bus
);

    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [7:0]    T_START    = 8'(STARTUP_T);
    localparam logic [7:0]    T_GMIN     = 8'(GREEN_MIN);
    localparam logic [7:0]    T_GMAX     = 8'(GREEN_MAX);
    localparam logic [7:0]    T_YEL      = 8'(YELLOW_T);
    localparam logic [7:0]    T_ALLRED   = 8'(ALLRED_T);

    // phase output exposes this encoding directly
    typedef enum logic [2:0] {
        ST_STARTUP = 3'd0,
        ST_ALLRED  = 3'd1,
        ST_GREEN   = 3'd2,
        ST_YELLOW  = 3'd3
    } state_t;

    state_t          state, state_nxt;
    logic [1:0]      cur, cur_nxt;
    logic [1:0]      last, last_nxt;
    logic [3:0]      pending, pending_nxt;
    logic [3:0]      green_mask, enter_mask;
    logic            enter_green;
    logic            others;
    logic            tick;
    logic [PW-1:0]   presc;
    logic [7:0]      elapsed, el_now;
    logic [3:0][1:0] lights_nxt;
    logic [3:0]      grant_nxt;

    // el_now is the elapsed tick count including a tick that lands this cycle
    assign tick   = (presc == PRESC_LAST);
    assign el_now = (tick && elapsed != 8'hFF) ? elapsed + 8'd1 : elapsed;
    assign others = |(pending & ~(4'b0001 << cur));

    function automatic logic [1:0] rr_pick(input logic [3:0] p, input logic [1:0] l);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = l;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = l + 2'(k);
            if (!found && p[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_nxt   = state;
        cur_nxt     = cur;
        last_nxt    = last;
        enter_green = 1'b0;
        case (state)
            ST_STARTUP: begin
                if (el_now >= T_START) state_nxt = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (el_now >= T_ALLRED) begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                    if (bus.emerg_req) begin
                        cur_nxt     = bus.emerg_dir;
                        last_nxt    = bus.emerg_dir;
                        enter_green = 1'b1;
                        state_nxt   = ST_GREEN;
                    end else
`endif
                    if (pending != 4'd0) begin
                        cur_nxt     = rr_pick(pending, last);
                        last_nxt    = cur_nxt;
                        enter_green = 1'b1;
                        state_nxt   = ST_GREEN;
                    end
                end
            end
            ST_GREEN: begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                if (bus.emerg_req) begin
                    if (bus.emerg_dir != cur) state_nxt = ST_YELLOW;
                end else
`endif
                if (others && ((el_now >= T_GMIN && !bus.req[cur]) || el_now >= T_GMAX))
                    state_nxt = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (el_now >= T_YEL) state_nxt = ST_ALLRED;
            end
            default: state_nxt = ST_ALLRED;
        endcase
    end

    // Requests for the approach currently green are not latched; entering green clears its bit.
    always_comb begin
        green_mask  = (state == ST_GREEN) ? (4'b0001 << cur) : 4'b0000;
        enter_mask  = enter_green ? (4'b0001 << cur_nxt) : 4'b0000;
        pending_nxt = (pending | (bus.req & ~green_mask)) & ~enter_mask;
        lights_nxt  = '0;
        grant_nxt   = 4'b0000;
        case (state_nxt)
            ST_STARTUP: lights_nxt = {4{2'b01}};
            ST_GREEN: begin
                lights_nxt[cur_nxt] = 2'b10;
                grant_nxt           = 4'b0001 << cur_nxt;
            end
            ST_YELLOW: begin
                lights_nxt[cur_nxt] = 2'b01;
                grant_nxt           = 4'b0001 << cur_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_STARTUP;
            cur       <= 2'd0;
            last      <= 2'd3;
            pending   <= 4'd0;
            presc     <= '0;
            elapsed   <= 8'd0;
            bus.north <= 2'b01;
            bus.east  <= 2'b01;
            bus.south <= 2'b01;
            bus.west  <= 2'b01;
            bus.grant <= 4'd0;
        end else begin
            state   <= state_nxt;
            cur     <= cur_nxt;
            last    <= last_nxt;
            pending <= pending_nxt;
            if (state_nxt != state) begin
                presc   <= '0;
                elapsed <= 8'd0;
            end else begin
                presc   <= tick ? '0 : presc + 1'b1;
                elapsed <= el_now;
            end
            bus.north <= lights_nxt[0];
            bus.east  <= lights_nxt[1];
            bus.south <= lights_nxt[2];
            bus.west  <= lights_nxt[3];
            bus.grant <= grant_nxt;
        end
    end

    assign bus.phase   = state;
    assign bus.pending = pending;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios plus random requests,
// every cycle compared against a cycle-count based model of the phase rules.
module tb_traffic_phase_scheduler;
    localparam int TD   = 4;
    localparam int ST_T = 3;
    localparam int GMIN = 5;
    localparam int GMAX = 15;
    localparam int YT   = 2;
    localparam int ART  = 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    bit   done     = 1'b0;

    traffic_phase_scheduler_if bus();

    traffic_phase_scheduler #(
        .TICK_DIV (TD),
        .STARTUP_T(ST_T),
        .GREEN_MIN(GMIN),
        .GREEN_MAX(GMAX),
        .YELLOW_T (YT),
        .ALLRED_T (ART)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 startup, 1 all-red, 2 green, 3 yellow; m_cyc = cycles spent in phase.
    int         m_ph   = 0;
    int         m_dir  = 0;
    int         m_last = 3;
    int         m_cyc  = 0;
    bit [3:0]   m_pend = 4'd0;
    logic [18:0] exp_q[$];
    logic [18:0] cmp_exp, cmp_act;

    function automatic logic [18:0] expected(input int ph, input int dir, input bit [3:0] pend);
        logic [1:0] l[4];
        logic [3:0] g;
        g = 4'd0;
        for (int j = 0; j < 4; j++) l[j] = (ph == 0) ? 2'b01 : 2'b00;
        if (ph == 2) begin l[dir] = 2'b10; g[dir] = 1'b1; end
        if (ph == 3) begin l[dir] = 2'b01; g[dir] = 1'b1; end
        return {l[0], l[1], l[2], l[3], g, 3'(ph), pend};
    endfunction

    task automatic model_step();
        int el, nph, ndir;
        bit entered, others;
        if (reset) begin
            m_ph = 0; m_dir = 0; m_last = 3; m_pend = 4'd0; m_cyc = 0;
            return;
        end
        el = (m_cyc + 1) / TD;
        if (el > 255) el = 255;
        nph = m_ph; ndir = m_dir; entered = 1'b0;
        if (m_ph == 0) begin
            if (el >= ST_T) nph = 1;
        end else if (m_ph == 1) begin
            if (el >= ART) begin
`ifdef TRAFFIC_EMERG_PREEMPT_EN
                if (bus.emerg_req) begin
                    ndir = int'(bus.emerg_dir); entered = 1'b1;
                end
`endif
                for (int k = 1; k <= 4; k++)
                    if (!entered && m_pend[(m_last + k) % 4]) begin
                        ndir = (m_last + k) % 4; entered = 1'b1;
                    end
                if (entered) begin nph = 2; m_last = ndir; end
            end
        end else if (m_ph == 2) begin
            others = (m_pend & ~(4'b0001 << m_dir)) != 4'd0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            if (bus.emerg_req) begin
                if (int'(bus.emerg_dir) != m_dir) nph = 3;
            end else
`endif
            if (others && ((el >= GMIN && !bus.req[m_dir]) || el >= GMAX)) nph = 3;
        end else if (m_ph == 3) begin
            if (el >= YT) nph = 1;
        end
        for (int j = 0; j < 4; j++)
            if (bus.req[j] && !(m_ph == 2 && m_dir == j)) m_pend[j] = 1'b1;
        if (entered) m_pend[ndir] = 1'b0;
        m_cyc = (nph != m_ph) ? 0 : m_cyc + 1;
        m_ph  = nph;
        m_dir = ndir;
    endtask

    always @(posedge clk) begin
        model_step();
        exp_q.push_back(expected(m_ph, m_dir, m_pend));
        #1;
        cmp_exp = exp_q.pop_front();
        cmp_act = {bus.north, bus.east, bus.south, bus.west, bus.grant, bus.phase, bus.pending};
        if (!done) check("cycle_outputs", 32'(cmp_act), 32'(cmp_exp));
    end

    task automatic wait_until(input logic [2:0] ph, input logic [3:0] g, input int maxc, output bit ok);
        int n;
        n = 0;
        while (!(bus.phase == ph && bus.grant == g) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        ok = (bus.phase == ph && bus.grant == g);
    endtask

    task automatic measure(input logic [2:0] ph, output int n);
        n = 0;
        while (bus.phase == ph && n < 500) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        bit ok;
        int n;
        bus.req = 4'd0;
`ifdef TRAFFIC_EMERG_PREEMPT_EN
        bus.emerg_req = 1'b0;
        bus.emerg_dir = 2'd0;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (11) @(negedge clk);
        check("startup_phase", 32'(bus.phase), 32'd0);
        check("startup_lights", 32'({bus.north, bus.east, bus.south, bus.west}), 32'h55);
        @(negedge clk);
        check("allred_phase", 32'(bus.phase), 32'd1);
        check("allred_lights", 32'({bus.north, bus.east, bus.south, bus.west}), 32'h00);
        repeat (10) @(negedge clk);
        check("idle_phase", 32'(bus.phase), 32'd1);
        check("idle_grant", 32'(bus.grant), 32'd0);

        // single north pulse while idle
        bus.req = 4'b0001;
        @(negedge clk);
        bus.req = 4'b0000;
        check("pulse_pending", 32'(bus.pending), 32'h1);
        @(negedge clk);
        check("pulse_north", 32'(bus.north), 32'h2);
        check("pulse_grant", 32'(bus.grant), 32'h1);
        check("pulse_pending_clr", 32'(bus.pending), 32'h0);
        repeat (20) @(negedge clk);
        check("rest_grant", 32'(bus.grant), 32'h1);
        check("rest_phase", 32'(bus.phase), 32'd2);

        // all approaches held: round robin with max-out
        bus.req = 4'hF;
        wait_until(3'd2, 4'b0010, 300, ok);
        check("rr_east_reached", 32'(ok), 32'd1);
        measure(3'd2, n);
        check("rr_green_len", 32'(n), 32'd60);
        measure(3'd3, n);
        check("rr_yellow_len", 32'(n), 32'd8);
        measure(3'd1, n);
        check("rr_allred_len", 32'(n), 32'd4);
        check("rr_south_grant", 32'(bus.grant), 32'h4);
        wait_until(3'd2, 4'b1000, 200, ok);
        check("rr_west_reached", 32'(ok), 32'd1);
        wait_until(3'd2, 4'b0001, 200, ok);
        check("rr_north_again", 32'(ok), 32'd1);

        // gap-out at GREEN_MIN
        bus.req = 4'b0011;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_until(3'd2, 4'b0001, 100, ok);
        check("gap_north_green", 32'(ok), 32'd1);
        n = 0;
        while (bus.phase == 3'd2 && bus.grant == 4'b0001 && n < 500) begin
            n++;
            if (n == 8) bus.req = 4'b0010;
            @(negedge clk);
        end
        check("gap_green_len", 32'(n), 32'd20);
        check("gap_yellow_phase", 32'(bus.phase), 32'd3);
        wait_until(3'd2, 4'b0010, 50, ok);
        check("gap_next_east", 32'(ok), 32'd1);

        // reset during YELLOW(S)
        bus.req = 4'b0100;
        wait_until(3'd2, 4'b0100, 200, ok);
        check("south_green", 32'(ok), 32'd1);
        bus.req = 4'b0001;
        wait_until(3'd3, 4'b0100, 200, ok);
        check("south_yellow", 32'(ok), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_lights", 32'({bus.north, bus.east, bus.south, bus.west}), 32'h55);
        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_pending", 32'(bus.pending), 32'd0);
        check("rst_phase", 32'(bus.phase), 32'd0);
        n = 0;
        while (bus.phase != 3'd2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_first_green_delay", 32'(n), 32'd16);
        check("rst_first_green_north", 32'(bus.grant), 32'h1);

`ifdef TRAFFIC_EMERG_PREEMPT_EN
        repeat (4) @(negedge clk);
        bus.emerg_req = 1'b1;
        bus.emerg_dir = 2'd2;
        @(negedge clk);
        check("emerg_yellow", 32'(bus.phase), 32'd3);
        wait_until(3'd2, 4'b0100, 50, ok);
        check("emerg_south", 32'(ok), 32'd1);
        repeat (100) @(negedge clk);
        check("emerg_hold", 32'(bus.grant), 32'h4);
        bus.emerg_req = 1'b0;
`endif

        // random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) bus.req = 4'($urandom_range(0, 15));
            reset = ($urandom_range(0, 499) == 0);
`ifdef TRAFFIC_EMERG_PREEMPT_EN
            if ($urandom_range(0, 99) == 0) begin
                bus.emerg_req = ~bus.emerg_req;
                bus.emerg_dir = 2'($urandom_range(0, 3));
            end
`endif
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        done = 1'b1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        n_errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
